// File: rtl/rca_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple-carry slice, LSB slice first.
// Optional signed-overflow output ovf is built when RCA_SEQ_OVF_EN is defined.

module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic c;

  always_comb begin
    s = '0;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

module rca_slice_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
`ifdef RCA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
`ifdef RCA_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [IDX_W+1:0] sh;
  logic [3:0]       slice_a, slice_b, slice_s;
  logic             slice_cout;

  // Bit offset of the active slice; shifts avoid variable part-selects.
  assign sh      = {idx_q, 2'b00};
  assign slice_a = 4'(a_q >> sh);
  assign slice_b = 4'(b_q >> sh);

  ripple_carry_adder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef RCA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d     = (s_q & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(slice_s) << sh);
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = DONE;
`ifdef RCA_SEQ_OVF_EN
          // Carry into the MSB recovered from the MSB sum bit, XORed with carry out.
          ovf_d   = (slice_a[3] ^ slice_b[3] ^ slice_s[3]) ^ slice_cout;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Captured operands are only read in RUN, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign cout      = cout_q;
`ifdef RCA_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Randomized bench for rca_slice_sequencer (WIDTH=16) against a plain-arithmetic model.
// Overflow checks are included when RCA_SEQ_OVF_EN is defined.

module tb_rca_slice_sequencer;
  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             busy;
`ifdef RCA_SEQ_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  rca_slice_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
`ifdef RCA_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One transaction: accept, check latency, hold in DONE for 'hold' cycles, release.
  // keep=1 leaves in_valid high with next operands na/nb for a back-to-back follow-up.
  task automatic do_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input int hold, input bit keep,
                        input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb);
    logic [WIDTH:0] exp;
    int w;
    exp = (WIDTH+1)'(ta) + (WIDTH+1)'(tb) + (WIDTH+1)'(tc);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    cin       = tc;
    out_ready = 1'b0;
    @(negedge clk);
    if (keep) begin
      a = na;
      b = nb;
    end else begin
      in_valid = 1'b0;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
    end
    check("in_ready_run", {31'd0, in_ready}, 32'd0);
    check("busy_run", {31'd0, busy}, 32'd1);
    for (int k = 0; k < NSLICE; k++) begin
      check("out_valid_early", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    check("out_valid_latency", {31'd0, out_valid}, 32'd1);
    check("sum", {16'd0, s}, {16'd0, exp[WIDTH-1:0]});
    check("cout", {31'd0, cout}, {31'd0, exp[WIDTH]});
`ifdef RCA_SEQ_OVF_EN
    check("ovf", {31'd0, ovf},
          {31'd0, (ta[WIDTH-1] == tb[WIDTH-1]) && (exp[WIDTH-1] != ta[WIDTH-1])});
`endif
    for (int h = 0; h < hold; h++) begin
      if (!keep) begin
        in_valid = (h == 0);
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
      end
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_sum", {16'd0, s}, {16'd0, exp[WIDTH-1:0]});
      check("hold_cout", {31'd0, cout}, {31'd0, exp[WIDTH]});
    end
    if (!keep) in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("released_valid", {31'd0, out_valid}, 32'd0);
    check("released_in_ready", {31'd0, in_ready}, 32'd1);
    if (!keep) check("released_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {16'd0, s}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_txn(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, '0, '0);
    do_txn(16'hFFFF, 16'hFFFF, 1'b1, 1, 1'b0, '0, '0);
    do_txn(16'h0000, 16'h0005, 1'b1, 0, 1'b0, '0, '0);
    do_txn(16'h1234, 16'h4321, 1'b0, 5, 1'b0, '0, '0);

    // Reset two edges after accept: partial result dropped, no out_valid afterwards.
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum", {16'd0, s}, 32'd0);
    check("midrst_cout", {31'd0, cout}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", {31'd0, seen}, 32'd0);

    // Reset and in_valid together: nothing captured.
    rst = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("rst_vs_valid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("rst_vs_valid_busy2", {31'd0, busy}, 32'd0);

    // Back-to-back with in_valid held high.
    do_txn(16'h000F, 16'h0001, 1'b0, 0, 1'b1, 16'h8000, 16'h8000);
    do_txn(16'h8000, 16'h8000, 1'b0, 0, 1'b0, '0, '0);

`ifdef RCA_SEQ_OVF_EN
    do_txn(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, '0, '0);
    do_txn(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, '0, '0);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: begin ra = 16'hFFFF; rb = 16'hFFFF; end
        1: begin ra = 16'hFFFF; rb = WIDTH'($urandom_range(0, 2)); end
        2: begin ra = 16'h7FFF; rb = WIDTH'($urandom); end
        default: begin ra = WIDTH'($urandom); rb = WIDTH'($urandom); end
      endcase
      do_txn(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), 1'b0, '0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
